// File: rtl/run_sequencer_pkg.sv
// Shared definitions for the run sequencer: FSM state encoding and the read-only
// program address table.
package run_sequencer_pkg;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_LOAD, SEQ_RUN, SEQ_DONE} seq_state_t;

  localparam int PROG_ADDR_W = 9;

  // Slot 3 is never selected (it is rejected as bad_sel); it mirrors P0 so the table is total.
  localparam logic [PROG_ADDR_W-1:0] PROG_START [4] = '{9'd0,   9'd436, 9'd481, 9'd0};
  localparam logic [PROG_ADDR_W-1:0] PROG_DONE  [4] = '{9'd435, 9'd480, 9'd511, 9'd435};

  function automatic logic [PROG_ADDR_W-1:0] prog_start_addr(input logic [1:0] sel);
    return PROG_START[sel];
  endfunction

  function automatic logic [PROG_ADDR_W-1:0] prog_done_addr(input logic [1:0] sel);
    return PROG_DONE[sel];
  endfunction

endpackage

// File: rtl/run_sequencer_timer.sv
// Saturating run-cycle counter with clear/enable and a flag for the last cycle
// before the watchdog limit.
module run_timer #(
  parameter int TIMER_BITS    = 16,
  parameter int TIMEOUT_LIMIT = 60000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  output logic [TIMER_BITS-1:0] count,
  output logic                  hit
);

  logic [TIMER_BITS-1:0] count_q;
  logic [TIMER_BITS-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != {TIMER_BITS{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  // High during the run cycle whose increment lands on TIMEOUT_LIMIT.
  assign hit   = (count_q == TIMER_BITS'(TIMEOUT_LIMIT - 1));

endmodule

// File: rtl/run_sequencer.sv
// Front-end run controller: latches a program select, loads its address pair into
// the program counter, pulses start, times the run and completes a req/ack handshake.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int PC_BITS       = 9,
  parameter int NUM_PROGS     = 3,
  parameter int TIMER_BITS    = 16,
  parameter int TIMEOUT_LIMIT = 60000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req,
  input  logic [1:0]            prog_sel,
  input  logic                  pc_done,
  output logic                  core_start,
  output logic [PC_BITS-1:0]    start_addr,
  output logic [PC_BITS-1:0]    done_addr,
  output logic                  ack,
  output logic                  busy,
  output logic                  timeout,
  output logic                  bad_sel,
  output logic [TIMER_BITS-1:0] cycle_count
);

  seq_state_t         state_q, state_d;
  logic               load_cnt_q, load_cnt_d;
  logic [1:0]         sel_q, sel_d;
  logic               core_start_q, core_start_d;
  logic [PC_BITS-1:0] start_addr_q, start_addr_d;
  logic [PC_BITS-1:0] done_addr_q, done_addr_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               timeout_q, timeout_d;
  logic               bad_sel_q, bad_sel_d;
  logic               timer_clear, timer_en, timer_hit;
  logic               sel_valid;

  assign sel_valid = (int'(prog_sel) < NUM_PROGS);

  run_timer #(
    .TIMER_BITS   (TIMER_BITS),
    .TIMEOUT_LIMIT(TIMEOUT_LIMIT)
  ) u_timer (
    .clock (clock),
    .reset (reset),
    .clear (timer_clear),
    .enable(timer_en),
    .count (cycle_count),
    .hit   (timer_hit)
  );

  always_comb begin
    state_d      = state_q;
    load_cnt_d   = load_cnt_q;
    sel_d        = sel_q;
    core_start_d = core_start_q;
    start_addr_d = start_addr_q;
    done_addr_d  = done_addr_q;
    ack_d        = ack_q;
    busy_d       = busy_q;
    timeout_d    = timeout_q;
    bad_sel_d    = bad_sel_q;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    case (state_q)
      SEQ_IDLE: begin
        if (req && sel_valid) begin
          state_d      = SEQ_LOAD;
          sel_d        = prog_sel;
          load_cnt_d   = 1'b0;
          core_start_d = 1'b1;
          busy_d       = 1'b1;
          start_addr_d = PC_BITS'(prog_start_addr(prog_sel));
          done_addr_d  = PC_BITS'(prog_done_addr(prog_sel));
          timeout_d    = 1'b0;
          bad_sel_d    = 1'b0;
          timer_clear  = 1'b1;
        end else if (req) begin
          // Rejected select: finish the handshake without touching the core.
          state_d   = SEQ_DONE;
          bad_sel_d = 1'b1;
          ack_d     = 1'b1;
        end
      end
      SEQ_LOAD: begin
        start_addr_d = PC_BITS'(prog_start_addr(sel_q));
        done_addr_d  = PC_BITS'(prog_done_addr(sel_q));
        if (load_cnt_q) begin
          state_d      = SEQ_RUN;
          core_start_d = 1'b0;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      SEQ_RUN: begin
        timer_en = 1'b1;
        if (pc_done || timer_hit) begin
          state_d   = SEQ_DONE;
          ack_d     = 1'b1;
          busy_d    = 1'b0;
          timeout_d = !pc_done;
        end
      end
      SEQ_DONE: begin
        if (!req) begin
          state_d = SEQ_IDLE;
          ack_d   = 1'b0;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= SEQ_IDLE;
      load_cnt_q   <= 1'b0;
      sel_q        <= 2'd0;
      core_start_q <= 1'b0;
      start_addr_q <= PC_BITS'(prog_start_addr(2'd0));
      done_addr_q  <= PC_BITS'(prog_done_addr(2'd0));
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      bad_sel_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_cnt_q   <= load_cnt_d;
      sel_q        <= sel_d;
      core_start_q <= core_start_d;
      start_addr_q <= start_addr_d;
      done_addr_q  <= done_addr_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      timeout_q    <= timeout_d;
      bad_sel_q    <= bad_sel_d;
    end
  end

  assign core_start = core_start_q;
  assign start_addr = start_addr_q;
  assign done_addr  = done_addr_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign timeout    = timeout_q;
  assign bad_sel    = bad_sel_q;

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a default-limit instance for handshake and
// address checks, and a TIMEOUT_LIMIT=20 instance for the watchdog.
module tb_run_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0, req_t = 1'b0;
  logic [1:0]  prog_sel = 2'd0, prog_sel_t = 2'd0;
  logic        pc_done = 1'b0, pc_done_t = 1'b0;

  logic        core_start, ack, busy, timeout, bad_sel;
  logic [8:0]  start_addr, done_addr;
  logic [15:0] cycle_count;
  logic        core_start_t, ack_t, busy_t, timeout_t, bad_sel_t;
  logic [8:0]  start_addr_t, done_addr_t;
  logic [15:0] cycle_count_t;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  run_sequencer dut (
    .clock(clock), .reset(reset), .req(req), .prog_sel(prog_sel), .pc_done(pc_done),
    .core_start(core_start), .start_addr(start_addr), .done_addr(done_addr),
    .ack(ack), .busy(busy), .timeout(timeout), .bad_sel(bad_sel), .cycle_count(cycle_count)
  );

  run_sequencer #(.TIMEOUT_LIMIT(20)) dut_t (
    .clock(clock), .reset(reset), .req(req_t), .prog_sel(prog_sel_t), .pc_done(pc_done_t),
    .core_start(core_start_t), .start_addr(start_addr_t), .done_addr(done_addr_t),
    .ack(ack_t), .busy(busy_t), .timeout(timeout_t), .bad_sel(bad_sel_t),
    .cycle_count(cycle_count_t)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_core_start", {31'b0, core_start}, 0);
    chk("rst_ack", {31'b0, ack}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_timeout", {31'b0, timeout}, 0);
    chk("rst_bad_sel", {31'b0, bad_sel}, 0);
    chk("rst_start_addr", {23'b0, start_addr}, 0);
    chk("rst_done_addr", {23'b0, done_addr}, 435);
    chk("rst_cycle_count", {16'b0, cycle_count}, 0);
    reset = 1'b0;
    tick();

    // Test 1: P0 run, pc_done in RUN cycle 100
    req = 1'b1; prog_sel = 2'd0;
    tick();
    chk("t1_load1_core_start", {31'b0, core_start}, 1);
    chk("t1_load1_busy", {31'b0, busy}, 1);
    chk("t1_start_addr", {23'b0, start_addr}, 0);
    chk("t1_done_addr", {23'b0, done_addr}, 435);
    tick();
    chk("t1_load2_core_start", {31'b0, core_start}, 1);
    tick();
    chk("t1_run_core_start", {31'b0, core_start}, 0);
    chk("t1_run_busy", {31'b0, busy}, 1);
    repeat (99) tick();
    chk("t1_run99_ack", {31'b0, ack}, 0);
    chk("t1_run99_count", {16'b0, cycle_count}, 99);
    pc_done = 1'b1;
    tick();
    pc_done = 1'b0;
    chk("t1_done_ack", {31'b0, ack}, 1);
    chk("t1_done_busy", {31'b0, busy}, 0);
    chk("t1_cycle_count", {16'b0, cycle_count}, 100);
    chk("t1_timeout", {31'b0, timeout}, 0);
    tick();
    chk("t1_ack_held", {31'b0, ack}, 1);

    // Test 2: drop req, P2 run, then P1 run
    req = 1'b0;
    tick();
    chk("t2_idle_ack", {31'b0, ack}, 0);
    req = 1'b1; prog_sel = 2'd2;
    tick();
    chk("t2_p2_start_addr", {23'b0, start_addr}, 481);
    chk("t2_p2_done_addr", {23'b0, done_addr}, 511);
    chk("t2_count_cleared", {16'b0, cycle_count}, 0);
    repeat (2) tick();
    pc_done = 1'b1;
    tick();
    pc_done = 1'b0;
    chk("t2_p2_ack", {31'b0, ack}, 1);
    chk("t2_p2_count", {16'b0, cycle_count}, 1);
    req = 1'b0;
    tick();
    chk("t2_ack_fall", {31'b0, ack}, 0);
    chk("t2_idle_busy", {31'b0, busy}, 0);
    req = 1'b1; prog_sel = 2'd1;
    tick();
    chk("t2_p1_start_addr", {23'b0, start_addr}, 436);
    chk("t2_p1_done_addr", {23'b0, done_addr}, 480);
    repeat (2) tick();
    pc_done = 1'b1;
    tick();
    pc_done = 1'b0;
    req = 1'b0;
    tick();
    chk("t2_p1_back_idle_ack", {31'b0, ack}, 0);

    // Test 3: invalid select
    req = 1'b1; prog_sel = 2'd3;
    tick();
    chk("t3_ack", {31'b0, ack}, 1);
    chk("t3_bad_sel", {31'b0, bad_sel}, 1);
    chk("t3_core_start", {31'b0, core_start}, 0);
    chk("t3_busy", {31'b0, busy}, 0);
    chk("t3_start_addr_kept", {23'b0, start_addr}, 436);
    chk("t3_done_addr_kept", {23'b0, done_addr}, 480);
    req = 1'b0;
    tick();
    chk("t3_idle_ack", {31'b0, ack}, 0);
    chk("t3_bad_sel_sticky", {31'b0, bad_sel}, 1);

    // Test 4: watchdog at limit 20
    req_t = 1'b1; prog_sel_t = 2'd0;
    repeat (3) tick();
    repeat (19) tick();
    chk("t4_run19_ack", {31'b0, ack_t}, 0);
    chk("t4_run19_busy", {31'b0, busy_t}, 1);
    tick();
    chk("t4_timeout", {31'b0, timeout_t}, 1);
    chk("t4_ack", {31'b0, ack_t}, 1);
    chk("t4_count", {16'b0, cycle_count_t}, 20);
    req_t = 1'b0;
    tick();
    chk("t4_timeout_sticky", {31'b0, timeout_t}, 1);
    req_t = 1'b1;
    tick();
    chk("t4_timeout_clr_load", {31'b0, timeout_t}, 0);
    repeat (2) tick();
    repeat (19) tick();
    pc_done_t = 1'b1;
    tick();
    pc_done_t = 1'b0;
    chk("t4v_ack", {31'b0, ack_t}, 1);
    chk("t4v_timeout", {31'b0, timeout_t}, 0);
    chk("t4v_count", {16'b0, cycle_count_t}, 20);
    req_t = 1'b0;
    tick();

    // Test 5: req dropped during LOAD/RUN
    req = 1'b1; prog_sel = 2'd0;
    tick();
    chk("t5_bad_sel_cleared", {31'b0, bad_sel}, 0);
    req = 1'b0;
    repeat (2) tick();
    repeat (5) tick();
    chk("t5_run_busy", {31'b0, busy}, 1);
    chk("t5_run_ack", {31'b0, ack}, 0);
    pc_done = 1'b1;
    tick();
    pc_done = 1'b0;
    chk("t5_ack", {31'b0, ack}, 1);
    chk("t5_count", {16'b0, cycle_count}, 6);
    tick();
    chk("t5_ack_one_cycle", {31'b0, ack}, 0);
    tick();
    chk("t5_stay_idle_busy", {31'b0, busy}, 0);
    chk("t5_stay_idle_core_start", {31'b0, core_start}, 0);

    // Test 6: async reset mid-RUN
    req = 1'b1; prog_sel = 2'd1;
    repeat (3) tick();
    repeat (3) tick();
    chk("t6_pre_busy", {31'b0, busy}, 1);
    #2 reset = 1'b1;
    #1;
    chk("t6_busy_drop", {31'b0, busy}, 0);
    chk("t6_core_start_drop", {31'b0, core_start}, 0);
    chk("t6_ack_drop", {31'b0, ack}, 0);
    chk("t6_count_drop", {16'b0, cycle_count}, 0);
    req = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("t6_idle_busy", {31'b0, busy}, 0);
    chk("t6_idle_ack", {31'b0, ack}, 0);
    chk("t6_idle_start_addr", {23'b0, start_addr}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
